// File: rtl/conv_1x1.sv
// Pointwise 1x1 convolution: scales every pixel of a rows x cols map by one
// signed fixed-point weight, requantises with saturation, and registers the map.
module conv_1x1 #(
  parameter int width     = 8,
  parameter int rows      = 3,
  parameter int cols      = 3,
  parameter int frac_bits = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [width-1:0] kernel,
  input  logic signed [width-1:0] pixel_in  [0:rows-1][0:cols-1],
  output logic signed [width-1:0] pixel_out [0:rows-1][0:cols-1]
);

  localparam int pw = 2 * width;

  // Saturation bounds sign-extended to the full product width.
  localparam logic signed [pw-1:0] sat_hi = {{(width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [pw-1:0] sat_lo = {{(width+1){1'b1}}, {(width-1){1'b0}}};

  for (genvar i = 0; i < rows; i++) begin : g_row
    for (genvar j = 0; j < cols; j++) begin : g_col
      logic signed [pw-1:0]    prod;
      logic signed [pw-1:0]    shifted;
      logic signed [width-1:0] sat;

      // Arithmetic shift floors toward -inf; no rounding is applied.
      always_comb begin
        prod    = pw'(pixel_in[i][j]) * pw'(kernel);
        shifted = prod >>> frac_bits;
        if (shifted > sat_hi)
          sat = sat_hi[width-1:0];
        else if (shifted < sat_lo)
          sat = sat_lo[width-1:0];
        else
          sat = shifted[width-1:0];
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
          pixel_out[i][j] <= '0;
        else
          pixel_out[i][j] <= sat;
      end
    end
  end

endmodule

// File: tb/tb_conv_1x1.sv
// Directed bench for conv_1x1: table of {kernel, map, expected map} vectors
// applied back to back, plus reset and hold-between-edges sequences.
module tb_conv_1x1;

  logic              CLK;
  logic              RST;
  logic signed [7:0] kernel;
  logic signed [7:0] pixel_in  [0:2][0:2];
  logic signed [7:0] pixel_out [0:2][0:2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] k;
    logic [7:0] p [9];
    logic [7:0] e [9];
    string      name;
  } vec_t;

  vec_t vecs [7];

  conv_1x1 #(.width(8), .rows(3), .cols(3), .frac_bits(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .kernel    (kernel),
    .pixel_in  (pixel_in),
    .pixel_out (pixel_out)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic drive(input logic [7:0] k, input logic [7:0] p [9]);
    kernel = k;
    for (int n = 0; n < 9; n++) pixel_in[n/3][n%3] = p[n];
  endtask

  task automatic check_map(input logic [7:0] e [9], input string name);
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (pixel_out[n/3][n%3] !== e[n]) begin
        errors++;
        $display("FAIL %s lane[%0d][%0d]: got %h expected %h", name, n/3, n%3,
                 pixel_out[n/3][n%3], e[n]);
      end
    end
  endtask

  logic [7:0] zeros [9];
  logic [7:0] inv   [9];

  initial begin
    vecs[0].name = "half";
    vecs[0].k = 8'h08;
    vecs[0].p = '{8'h10, 8'h18, 8'h08, 8'hF0, 8'h00, 8'h1C, 8'h04, 8'hE8, 8'h1E};
    vecs[0].e = '{8'h08, 8'h0C, 8'h04, 8'hF8, 8'h00, 8'h0E, 8'h02, 8'hF4, 8'h0F};
    vecs[1].name = "identity";
    vecs[1].k = 8'h10;
    vecs[1].p = vecs[0].p;
    vecs[1].e = vecs[0].p;
    vecs[2].name = "zero_kernel";
    vecs[2].k = 8'h00;
    vecs[2].p = vecs[0].p;
    vecs[2].e = '{default: 8'h00};
    vecs[3].name = "sat_k2";
    vecs[3].k = 8'h20;
    vecs[3].p = '{8'h7F, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h40, 8'hC0, 8'h3F, 8'hC1};
    vecs[3].e = '{8'h7F, 8'h80, 8'h02, 8'hFE, 8'h00, 8'h7F, 8'h80, 8'h7E, 8'h82};
    vecs[4].name = "sat_kneg8";
    vecs[4].k = 8'h80;
    vecs[4].p = '{8'h80, 8'h7F, 8'h01, 8'hFF, 8'h00, 8'h10, 8'hF0, 8'h02, 8'hFE};
    vecs[4].e = '{8'h7F, 8'h80, 8'hF8, 8'h08, 8'h00, 8'h80, 8'h7F, 8'hF0, 8'h10};
    vecs[5].name = "kneg1";
    vecs[5].k = 8'hF0;
    vecs[5].p = '{8'h7F, 8'h80, 8'h01, 8'hFF, 8'h10, 8'h00, 8'h08, 8'hF8, 8'h40};
    vecs[5].e = '{8'h81, 8'h7F, 8'hFF, 8'h01, 8'hF0, 8'h00, 8'hF8, 8'h08, 8'hC0};
    vecs[6].name = "truncate";
    vecs[6].k = 8'h08;
    vecs[6].p = '{8'h01, 8'hFF, 8'h02, 8'hFE, 8'h03, 8'hFD, 8'h1F, 8'hE1, 8'h00};
    vecs[6].e = '{8'h00, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'hFE, 8'h0F, 8'hF0, 8'h00};
    zeros = '{default: 8'h00};

    // Reset held with live inputs: clock edges must not load anything.
    RST = 1'b0;
    drive(vecs[0].k, vecs[0].p);
    #1;
    check_map(zeros, "reset_initial");
    repeat (3) @(posedge CLK);
    #1;
    check_map(zeros, "reset_held");

    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_map(vecs[0].e, "first_after_reset");

    // Back-to-back vectors: each result one edge later, held between edges.
    for (int v = 0; v < 7; v++) begin
      @(negedge CLK);
      drive(vecs[v].k, vecs[v].p);
      @(posedge CLK);
      #1;
      check_map(vecs[v].e, vecs[v].name);
      for (int n = 0; n < 9; n++) inv[n] = ~vecs[v].p[n];
      drive(~vecs[v].k, inv);
      #2;
      check_map(vecs[v].e, {vecs[v].name, "_hold"});
    end

    // Mid-run asynchronous reset clears outputs without a clock edge.
    @(negedge CLK);
    drive(vecs[3].k, vecs[3].p);
    @(posedge CLK);
    #1;
    check_map(vecs[3].e, "pre_async_reset");
    #2;
    RST = 1'b0;
    #1;
    check_map(zeros, "async_reset");
    @(posedge CLK);
    #1;
    check_map(zeros, "async_reset_edge");
    @(negedge CLK);
    RST = 1'b1;
    drive(vecs[5].k, vecs[5].p);
    @(posedge CLK);
    #1;
    check_map(vecs[5].e, "after_async_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
